// File: rtl/trap_ctrl.sv
// Trap sequencer: captures ecall/ebreak/mret/timer events at retirement, drains
// the pipeline, issues one CSR update strobe and then redirects fetch.
module trap_ctrl #(
   parameter int XLEN      = 64,
   parameter int DRAIN_MAX = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [XLEN-1:0] wb_next_pc,
   input  logic            wb_ecall,
   input  logic            wb_ebreak,
   input  logic            wb_mret,
   input  logic            clint_mtip,
   input  logic            mstatus_mie,
   input  logic            mie_mtie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic            pipe_idle,
   input  logic            redirect_ready,
   output logic            busy,
   output logic            flush,
   output logic            csr_trap_we,
   output logic            csr_mret_we,
   output logic [XLEN-1:0] trap_mcause,
   output logic [XLEN-1:0] trap_mepc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            drain_err
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DRAIN    = 2'd1;
   localparam logic [1:0] S_COMMIT   = 2'd2;
   localparam logic [1:0] S_REDIRECT = 2'd3;

   localparam logic [7:0]      DRAIN_LIMIT   = 8'(DRAIN_MAX);
   localparam logic [XLEN-1:0] MCAUSE_ECALL  = XLEN'(11);
   localparam logic [XLEN-1:0] MCAUSE_EBREAK = XLEN'(3);
   localparam logic [XLEN-1:0] MCAUSE_MTI    = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);

   logic [1:0]      r_state;
   logic            r_kind_mret;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_redirect_pc;
   logic [7:0]      r_cnt;
   logic            r_drain_err;

   logic            w_irq;
   logic            w_sync;
   logic [7:0]      w_cnt_inc;
   logic [XLEN-1:0] w_tvec_base;
   logic [XLEN-1:0] w_target;

   // The timer line is level-sensitive, so a deferred interrupt simply stays visible.
   assign w_irq       = clint_mtip & mstatus_mie & mie_mtie;
   assign w_sync      = wb_ecall | wb_ebreak | wb_mret;
   assign w_cnt_inc   = r_cnt + 8'd1;
   assign w_tvec_base = {mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      w_target = w_tvec_base;
      if (r_kind_mret)
         w_target = mepc;
      else if (mtvec[1:0] == 2'b01 && r_mcause[XLEN-1])
         w_target = w_tvec_base + {r_mcause[XLEN-3:0], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_kind_mret   <= 1'b0;
         r_mcause      <= '0;
         r_mepc        <= '0;
         r_redirect_pc <= '0;
         r_cnt         <= '0;
         r_drain_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (wb_valid && (w_sync || w_irq)) begin
                  r_state     <= S_DRAIN;
                  r_cnt       <= '0;
                  r_kind_mret <= wb_mret && !wb_ecall && !wb_ebreak;
               end
               if (wb_valid) begin
                  if (wb_ecall) begin
                     r_mcause <= MCAUSE_ECALL;
                     r_mepc   <= wb_pc;
                  end else if (wb_ebreak) begin
                     r_mcause <= MCAUSE_EBREAK;
                     r_mepc   <= wb_pc;
                  end else if (!wb_mret && w_irq) begin
                     r_mcause <= MCAUSE_MTI;
                     r_mepc   <= wb_next_pc;
                  end
               end
            end
            S_DRAIN: begin
               r_cnt <= w_cnt_inc;
               if (pipe_idle) begin
                  r_state <= S_COMMIT;
               end else if (w_cnt_inc == DRAIN_LIMIT) begin
                  r_drain_err <= 1'b1;
                  r_state     <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               r_redirect_pc <= w_target;
               r_state       <= S_REDIRECT;
            end
            S_REDIRECT: begin
               if (redirect_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign flush          = (r_state == S_DRAIN) && (r_cnt == 8'd0);
   assign csr_trap_we    = (r_state == S_COMMIT) && !r_kind_mret;
   assign csr_mret_we    = (r_state == S_COMMIT) && r_kind_mret;
   assign trap_mcause    = r_mcause;
   assign trap_mepc      = r_mepc;
   assign redirect_valid = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign drain_err      = r_drain_err;

   // Retirement must be stalled while a sequence is in flight.
   a_no_retire_when_busy: assert property (@(posedge clk) disable iff (rst) !(busy && wb_valid));

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: each event pushes its expected CSR update and
// redirect target; a monitor pops and compares when the DUT commits and redirects.
module tb_trap_ctrl;
   localparam int XLEN = 64;
   localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

   logic            clk = 1'b0;
   logic            rst;
   logic            wb_valid, wb_ecall, wb_ebreak, wb_mret;
   logic [XLEN-1:0] wb_pc, wb_next_pc, mtvec, mepc;
   logic            clint_mtip, mstatus_mie, mie_mtie, pipe_idle, redirect_ready;
   logic            busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err;
   logic [XLEN-1:0] trap_mcause, trap_mepc, redirect_pc;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(255)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
      .wb_ecall(wb_ecall), .wb_ebreak(wb_ebreak), .wb_mret(wb_mret),
      .clint_mtip(clint_mtip), .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie),
      .mtvec(mtvec), .mepc(mepc), .pipe_idle(pipe_idle), .redirect_ready(redirect_ready),
      .busy(busy), .flush(flush), .csr_trap_we(csr_trap_we), .csr_mret_we(csr_mret_we),
      .trap_mcause(trap_mcause), .trap_mepc(trap_mepc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .drain_err(drain_err)
   );

   typedef struct {
      logic        is_mret;
      logic [63:0] mcause;
      logic [63:0] mepc;
      logic [63:0] target;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int n_vec = 0, n_err = 0;
   int n_flush = 0, n_trap = 0, n_mret = 0;

   function automatic logic [63:0] model_target(input logic [63:0] tvec, input logic [63:0] cause);
      logic [63:0] base;
      base = tvec & ~64'h3;
      if (tvec[1:0] == 2'b01 && cause[63])
         return base + 64'd4 * (cause & 64'h7FFF_FFFF_FFFF_FFFF);
      return base;
   endfunction

   task automatic push_trap(input logic [63:0] cause, input logic [63:0] pc);
      exp_t e;
      e.is_mret = 1'b0; e.mcause = cause; e.mepc = pc; e.target = model_target(mtvec, cause);
      sb.push_back(e);
   endtask

   task automatic push_mret();
      exp_t e;
      e.is_mret = 1'b1; e.mcause = '0; e.mepc = '0; e.target = mepc;
      sb.push_back(e);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (flush) n_flush++;
         if (csr_trap_we) n_trap++;
         if (csr_mret_we) n_mret++;
         if (csr_trap_we || csr_mret_we) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_strobe: trap_we=%b mret_we=%b required none", csr_trap_we, csr_mret_we);
            end else begin
               e_mon = sb[0];
               if ((csr_trap_we && csr_mret_we) || (csr_mret_we !== e_mon.is_mret)) begin
                  n_err++;
                  $display("FAIL strobe_kind: trap_we=%b mret_we=%b required mret=%b", csr_trap_we, csr_mret_we, e_mon.is_mret);
               end
               if (csr_trap_we && !e_mon.is_mret) begin
                  n_vec++;
                  if (trap_mcause !== e_mon.mcause) begin
                     n_err++;
                     $display("FAIL mcause: got %h required %h", trap_mcause, e_mon.mcause);
                  end
                  n_vec++;
                  if (trap_mepc !== e_mon.mepc) begin
                     n_err++;
                     $display("FAIL mepc: got %h required %h", trap_mepc, e_mon.mepc);
                  end
               end
            end
         end
         if (redirect_valid && redirect_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_redirect: pc=%h required none", redirect_pc);
            end else begin
               e_mon = sb[0];
               void'(sb.pop_front());
               if (redirect_pc !== e_mon.target) begin
                  n_err++;
                  $display("FAIL redirect_pc: got %h required %h", redirect_pc, e_mon.target);
               end
            end
         end
      end
   end

   // Starts in the cycle after a posedge (#1) with the DUT idle; returns at posedge+#1 once idle.
   task automatic do_event(input string tag, input logic ec, input logic eb, input logic mr,
                           input logic [63:0] pc, input logic [63:0] npc,
                           input int idle_dly, input int ready_dly,
                           output int lat, output int drain_k, output int unstable);
      int rv;
      logic [63:0] pc0;
      rv = 0; lat = 0; drain_k = 0; unstable = 0; pc0 = '0;
      wb_valid = 1'b1; wb_pc = pc; wb_next_pc = npc;
      wb_ecall = ec; wb_ebreak = eb; wb_mret = mr;
      pipe_idle = (idle_dly == 0);
      redirect_ready = (ready_dly == 0);
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            wb_valid = 1'b0; wb_ecall = 1'b0; wb_ebreak = 1'b0; wb_mret = 1'b0;
         end
         lat = k;
         if (drain_err && drain_k == 0) drain_k = k;
         if (!busy) break;
         if (k >= idle_dly) pipe_idle = 1'b1;
         if (redirect_valid) begin
            rv++;
            if (rv == 1) pc0 = redirect_pc;
            else if (redirect_pc !== pc0) unstable++;
            if (rv > ready_dly) redirect_ready = 1'b1;
         end
      end
      $display("txn %s pc=%h lat=%0d drain_err_at=%0d", tag, pc, lat, drain_k);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 000000", {busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err});
      end
      n_vec++;
      if ({trap_mcause, trap_mepc, redirect_pc} !== 192'b0) begin
         n_err++;
         $display("FAIL reset_regs: got %h %h %h required 0", trap_mcause, trap_mepc, redirect_pc);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_ecall();
      int lat, dk, us, f0, t0;
      mtvec = 64'h8000_0100;
      f0 = n_flush; t0 = n_trap;
      push_trap(64'd11, 64'h8000_0010);
      do_event("ecall", 1, 0, 0, 64'h8000_0010, 64'h8000_0014, 0, 0, lat, dk, us);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL ecall_latency: got %0d required 4", lat); end
      n_vec++;
      if (n_flush - f0 !== 1) begin n_err++; $display("FAIL ecall_flush_cycles: got %0d required 1", n_flush - f0); end
      n_vec++;
      if (n_trap - t0 !== 1) begin n_err++; $display("FAIL ecall_trap_we_count: got %0d required 1", n_trap - t0); end
   endtask

   task automatic test_ebreak();
      int lat, dk, us;
      mtvec = 64'h8000_0401;  // vectored, but exceptions still use the base
      push_trap(64'd3, 64'h8000_0040);
      do_event("ebreak", 0, 1, 0, 64'h8000_0040, 64'h8000_0044, 0, 0, lat, dk, us);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL ebreak_latency: got %0d required 4", lat); end
   endtask

   task automatic test_mret_delayed();
      int lat, dk, us, m0, t0;
      mepc = 64'h8000_0014;
      m0 = n_mret; t0 = n_trap;
      push_mret();
      do_event("mret", 0, 0, 1, 64'h8000_0100, 64'h8000_0104, 3, 2, lat, dk, us);
      n_vec++;
      if (n_mret - m0 !== 1 || n_trap - t0 !== 0) begin
         n_err++;
         $display("FAIL mret_strobes: mret=%0d trap=%0d required 1 0", n_mret - m0, n_trap - t0);
      end
      n_vec++;
      if (us !== 0) begin n_err++; $display("FAIL mret_pc_stable: changes=%0d required 0", us); end
      n_vec++;
      if (lat !== 8) begin n_err++; $display("FAIL mret_latency: got %0d required 8", lat); end
      n_vec++;
      if (trap_mcause !== 64'd3 || trap_mepc !== 64'h8000_0040) begin
         n_err++;
         $display("FAIL mcause_hold: got %h %h required 3 80000040", trap_mcause, trap_mepc);
      end
   endtask

   task automatic test_timer_irq();
      int lat, dk, us;
      mtvec = 64'h8000_0101;
      clint_mtip = 1'b1; mstatus_mie = 1'b0; mie_mtie = 1'b1;
      // Masked interrupt: a plain retire must not start a sequence.
      wb_valid = 1'b1; wb_pc = 64'h8000_001C; wb_next_pc = 64'h8000_0020;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL irq_masked: busy=%b required 0", busy); end
      mstatus_mie = 1'b1;
      // Enabled interrupt but no retirement: nothing happens between instructions.
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL irq_no_retire: busy=%b required 0", busy); end
      push_trap(IRQ_CAUSE, 64'h8000_0020);
      do_event("timer_irq", 0, 0, 0, 64'h8000_001C, 64'h8000_0020, 0, 0, lat, dk, us);
      n_vec++;
      if (lat !== 4) begin n_err++; $display("FAIL irq_latency: got %0d required 4", lat); end
      clint_mtip = 1'b0;
   endtask

   task automatic test_priority();
      int lat, dk, us;
      mtvec = 64'h8000_0201;
      clint_mtip = 1'b1; mstatus_mie = 1'b1; mie_mtie = 1'b1;
      push_trap(64'd11, 64'h8000_0300);
      do_event("ecall+irq", 1, 0, 0, 64'h8000_0300, 64'h8000_0304, 0, 0, lat, dk, us);
      mepc = 64'h8000_0304;
      push_mret();
      do_event("mret+irq", 0, 0, 1, 64'h8000_0210, 64'h8000_0214, 0, 0, lat, dk, us);
      push_trap(IRQ_CAUSE, 64'h8000_0308);
      do_event("irq_after_mret", 0, 0, 0, 64'h8000_0304, 64'h8000_0308, 0, 0, lat, dk, us);
      n_vec++;
      if (trap_mcause !== IRQ_CAUSE) begin
         n_err++;
         $display("FAIL irq_not_lost: mcause=%h required %h", trap_mcause, IRQ_CAUSE);
      end
      clint_mtip = 1'b0;
   endtask

   task automatic test_drain_timeout();
      int lat, dk, us;
      mtvec = 64'h0000_1000;
      push_trap(64'd3, 64'h0000_2000);
      do_event("drain_timeout", 0, 1, 0, 64'h0000_2000, 64'h0000_2004, 100000, 0, lat, dk, us);
      n_vec++;
      if (dk !== 256) begin n_err++; $display("FAIL drain_err_cycle: got %0d required 256", dk); end
      n_vec++;
      if (lat !== 258) begin n_err++; $display("FAIL drain_timeout_latency: got %0d required 258", lat); end
      n_vec++;
      if (drain_err !== 1'b1) begin n_err++; $display("FAIL drain_err_set: got %b required 1", drain_err); end
   endtask

   task automatic test_back_to_back();
      int lat, dk, us, kind;
      logic [63:0] pc, tv;
      mstatus_mie = 1'b1; mie_mtie = 1'b1;
      for (int i = 0; i < 6; i++) begin
         kind = $urandom_range(0, 2);
         pc = {$urandom, $urandom} & ~64'h3;
         tv = {$urandom, $urandom};
         tv[1:0] = (i % 2 == 0) ? 2'b01 : tv[1:0];
         mtvec = tv;
         clint_mtip = (kind == 2);
         if (kind == 0) push_trap(64'd11, pc);
         else if (kind == 1) push_trap(64'd3, pc);
         else push_trap(IRQ_CAUSE, pc + 64'd4);
         do_event("b2b", kind == 0, kind == 1, 0, pc, pc + 64'd4, 0, 0, lat, dk, us);
         n_vec++;
         if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d required 4", lat); end
         clint_mtip = 1'b0;
      end
      n_vec++;
      if (drain_err !== 1'b1) begin n_err++; $display("FAIL drain_err_sticky: got %b required 1", drain_err); end
   endtask

   task automatic test_reset_abort();
      int t0;
      bit seen;
      // Abort while draining.
      mtvec = 64'h8000_0100; pipe_idle = 1'b0; redirect_ready = 1'b1;
      wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 64'h8000_0500;
      @(posedge clk); #1;
      wb_valid = 1'b0; wb_ecall = 1'b0;
      @(posedge clk); #1;
      t0 = n_trap + n_mret;
      rst = 1'b1; pipe_idle = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if ({busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err, trap_mcause, trap_mepc, redirect_pc} !== '0) begin
         n_err++;
         $display("FAIL abort_drain_outputs: got %b %h %h %h required 0", {busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err}, trap_mcause, trap_mepc, redirect_pc);
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (n_trap + n_mret !== t0) begin n_err++; $display("FAIL abort_drain_strobe: got %0d required 0", n_trap + n_mret - t0); end
      $display("txn abort_in_drain pc=%h", 64'h8000_0500);
      // Abort while waiting for the redirect handshake.
      redirect_ready = 1'b0;
      push_trap(64'd11, 64'h8000_0600);
      wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 64'h8000_0600;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         wb_valid = 1'b0; wb_ecall = 1'b0;
         if (redirect_valid) begin seen = 1'b1; break; end
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL abort_reach_redirect: redirect_valid=%b required 1", redirect_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      t0 = n_trap + n_mret;
      n_vec++;
      if ({busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err, trap_mcause, trap_mepc, redirect_pc} !== '0) begin
         n_err++;
         $display("FAIL abort_redirect_outputs: got %b %h %h %h required 0", {busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err}, trap_mcause, trap_mepc, redirect_pc);
      end
      redirect_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (n_trap + n_mret !== t0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_redirect_after: strobes=%0d busy=%b required 0 0", n_trap + n_mret - t0, busy);
      end
      $display("txn abort_in_redirect pc=%h", 64'h8000_0600);
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; wb_ecall = 1'b0; wb_ebreak = 1'b0; wb_mret = 1'b0;
      wb_pc = '0; wb_next_pc = '0; mtvec = '0; mepc = '0;
      clint_mtip = 1'b0; mstatus_mie = 1'b0; mie_mtie = 1'b0;
      pipe_idle = 1'b1; redirect_ready = 1'b1;
      test_reset();
      test_ecall();
      test_ebreak();
      test_mret_delayed();
      test_timer_irq();
      test_priority();
      test_drain_timeout();
      test_back_to_back();
      test_reset_abort();
      n_vec++;
      if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drained: left=%0d required 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter XLEN, 64, data/address width of PC, mtvec, mepc, mcause.
REQ-002 Parameter DRAIN_MAX, 255, max cycles in DRAIN before timeout; counter width 8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wb_valid  in  1  one instruction retiring this cycle.
REQ-006 wb_pc / wb_next_pc  in  XLEN  PC of retiring instruction / its sequential-or-branch successor.
REQ-007 wb_ecall, wb_ebreak, wb_mret  in  1 each  retiring instruction class; at most one set.
REQ-008 clint_mtip, mstatus_mie, mie_mtie  in  1 each  timer pending, global enable, timer enable.
REQ-009 mtvec, mepc  in  XLEN  current CSR values.
REQ-010 pipe_idle  in  1  no younger instruction or bus transaction outstanding.
REQ-011 redirect_ready  in  1  fetch accepts redirect.
REQ-012 busy  out  1  state != IDLE; also stalls retirement.
REQ-013 flush  out  1  one-cycle pulse, kill younger instructions.
REQ-014 csr_trap_we / csr_mret_we  out  1 each  one-cycle CSR update strobes.
REQ-015 trap_mcause / trap_mepc  out  XLEN  values written with csr_trap_we.
REQ-016 redirect_valid  out  1; redirect_pc  out  XLEN.
REQ-017 drain_err  out  1  sticky DRAIN timeout flag.

Function
REQ-018 States: IDLE, DRAIN, COMMIT, REDIRECT; one-hot or binary, implementer's choice.
REQ-019 IDLE, wb_valid & wb_ecall: latch mcause=11, mepc=wb_pc, kind=TRAP; go DRAIN.
REQ-020 IDLE, wb_valid & wb_ebreak: latch mcause=3, mepc=wb_pc, kind=TRAP; go DRAIN.
REQ-021 IDLE, wb_valid & wb_mret: kind=MRET; go DRAIN.
REQ-022 IDLE, wb_valid, no ecall/ebreak/mret, clint_mtip & mstatus_mie & mie_mtie: latch mcause=2^(XLEN-1)+7, mepc=wb_next_pc, kind=TRAP; go DRAIN.
REQ-023 Priority same cycle: ecall/ebreak/mret over interrupt; interrupt stays pending, not lost.
REQ-024 No event without wb_valid; interrupt never taken between instructions.
REQ-025 flush pulses exactly one cycle: the first DRAIN cycle.
REQ-026 DRAIN: counter cleared on entry, +1 per cycle; pipe_idle -> COMMIT next edge.
REQ-027 DRAIN counter reaching DRAIN_MAX without pipe_idle: set drain_err, proceed to COMMIT.
REQ-028 COMMIT: exactly one cycle; kind=TRAP -> csr_trap_we=1 with trap_mcause/trap_mepc valid; kind=MRET -> csr_mret_we=1.
REQ-029 COMMIT target captured into redirect_pc: TRAP, mtvec[1:0]=01 and mcause MSB=1 -> {mtvec[XLEN-1:2],2'b00}+4*mcause[XLEN-2:0]; other TRAP -> {mtvec[XLEN-1:2],2'b00}; MRET -> mepc.
REQ-030 Target arithmetic modulo 2^XLEN, no overflow detection.
REQ-031 REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready; handshake cycle -> IDLE next edge.
REQ-032 redirect_ready outside REDIRECT ignored.
REQ-033 busy=1 in DRAIN/COMMIT/REDIRECT; wb_valid while busy ignored (protocol violation, assertion).
REQ-034 Minimum event-to-IDLE: 4 cycles (capture, DRAIN with pipe_idle, COMMIT, REDIRECT with ready).
REQ-035 trap_mcause/trap_mepc hold last latched values outside COMMIT.

Reset
REQ-036 rst: state IDLE; busy, flush, csr_trap_we, csr_mret_we, redirect_valid, drain_err 0; trap_mcause, trap_mepc, redirect_pc, counter 0.
REQ-037 rst in any state aborts sequence; no strobe issued after the reset edge.
REQ-038 drain_err clears only on rst.

Verification
REQ-039 ecall at wb_pc=0x8000_0010, mtvec=0x8000_0100, pipe_idle=1, ready=1 -> flush 1 cycle, csr_trap_we with mcause=11/mepc=0x8000_0010, redirect_pc=0x8000_0100, IDLE after 4 cycles.
REQ-040 mret, mepc=0x8000_0014, pipe_idle delayed 3 cycles, ready delayed 2 -> csr_mret_we once, redirect_pc=0x8000_0014 held stable until ready.
REQ-041 timer pending + enables, non-trap retire, wb_next_pc=0x8000_0020, mtvec=0x8000_0101 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0020, redirect_pc=0x8000_011C.
REQ-042 ecall and mtip same cycle -> mcause=11; after mret with MIE set, interrupt taken on next retire.
REQ-043 pipe_idle held 0 -> drain_err=1 after 255 DRAIN cycles, COMMIT follows; stays set until rst.
REQ-044 rst asserted in DRAIN and in REDIRECT -> IDLE next edge, no csr_trap_we/csr_mret_we, all outputs at reset values.
